// File: rtl/msgPass_config_pkg.sv
// Shared configuration for the message-pass request address sequencer.
// Holds default parameter values and the sequencer state encoding.
package msgPass_config_pkg;

   localparam int DEF_DEPTH      = 16;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_CH_NUM     = 2;
   localparam int DEF_DRC_NUM    = 1;
   localparam int DEF_LEN_WIDTH  = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/msgpass_addr_wrap_add.sv
// Modulo-DEPTH page address adder; operands must already be below DEPTH.
// One extra bit of headroom, at most one DEPTH subtraction.
module msgpass_addr_wrap_add #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic [ADDR_WIDTH-1:0] a_i,
   input  logic [ADDR_WIDTH-1:0] b_i,
   output logic [ADDR_WIDTH-1:0] sum_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH:0] sum;

   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   assign sum_o = (sum >= DEPTH_W) ? ADDR_WIDTH'(sum - DEPTH_W)
                                   : sum[ADDR_WIDTH-1:0];

endmodule

// File: rtl/msgpass_rqst_addr_seq.sv
// Strided multi-channel page address sequencer for message-pass reads.
// Single FSM with stall on request conflict and abort on read_end_i.
module msgpass_rqst_addr_seq
   import msgPass_config_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int DRC_NUM    = DEF_DRC_NUM,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                         sys_clk,
   input  logic                         rstn,
   input  logic                         read_begin_i,
   input  logic                         read_end_i,
   input  logic [ADDR_WIDTH-1:0]        base_addr_i,
   input  logic [ADDR_WIDTH-1:0]        stride_i,
   input  logic [LEN_WIDTH-1:0]         len_i,
   input  logic [CH_NUM-1:0]            ch_en_i,
   input  logic [DRC_NUM-1:0]           is_drc_i,
   output logic [CH_NUM*ADDR_WIDTH-1:0] addr_o,
   output logic [CH_NUM-1:0]            addr_valid_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         aborted_o,
   output logic [LEN_WIDTH-1:0]         step_cnt_o
);

   localparam int AW = ADDR_WIDTH;
   localparam int LW = LEN_WIDTH;

   state_e                state_q, state_d;
   logic [AW-1:0]         cur_q, cur_d;
   logic [AW-1:0]         stride_q, stride_d;
   logic [AW-1:0]         cur_adv;
   logic [LW-1:0]         len_q, len_d;
   logic [LW-1:0]         cnt_q, cnt_d;
   logic [LW-1:0]         cnt_inc;
   logic [CH_NUM-1:0]     ch_en_q, ch_en_d;
   logic [CH_NUM-1:0]     valid_q, valid_d;
   logic [CH_NUM*AW-1:0]  addr_q, addr_d;
   logic [CH_NUM*AW-1:0]  addr_off;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  abort_q, abort_d;
   logic                  load;
   logic                  stall;

   assign stall   = |is_drc_i;
   assign cnt_inc = cnt_q + LW'(1);

   msgpass_addr_wrap_add #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_adv (
      .a_i   (cur_q),
      .b_i   (stride_q),
      .sum_o (cur_adv)
   );

   // Channel offsets are taken from the next step address so they register together.
   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      msgpass_addr_wrap_add #(
         .DEPTH      (DEPTH),
         .ADDR_WIDTH (AW)
      ) u_off (
         .a_i   (cur_d),
         .b_i   (AW'(k)),
         .sum_o (addr_off[k*AW +: AW])
      );
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      stride_d = stride_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      ch_en_d  = ch_en_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      load     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (read_begin_i) begin
               stride_d = stride_i;
               len_d    = len_i;
               ch_en_d  = ch_en_i;
               cur_d    = base_addr_i;
               cnt_d    = '0;
               if (len_i == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  load    = 1'b1;
               end
            end
         end
         ST_RUN, ST_STALL: begin
            if (read_end_i) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               valid_d = '0;
               done_d  = 1'b1;
               abort_d = 1'b1;
            end else if (stall) begin
               state_d = ST_STALL;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  valid_d = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  cur_d   = cur_adv;
                  load    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load) begin
         addr_d  = addr_off;
         valid_d = ch_en_d;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         stride_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         ch_en_q  <= '0;
         valid_q  <= '0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         stride_q <= stride_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         ch_en_q  <= ch_en_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
      end
   end

   assign addr_o       = addr_q;
   assign addr_valid_o = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign aborted_o    = abort_q;
   assign step_cnt_o   = cnt_q;

endmodule

// File: tb/tb_msgpass_rqst_addr_seq.sv
// Bench for msgpass_rqst_addr_seq: DEPTH=16 and DEPTH=10 instances
// checked every cycle against a step-index reference model.
module tb_msgpass_rqst_addr_seq;

   localparam int AW  = 4;
   localparam int CH  = 2;
   localparam int DRC = 2;
   localparam int LW  = 5;

   logic sys_clk = 1'b0;
   logic rstn    = 1'b1;

   always #5 sys_clk = ~sys_clk;

   logic           read_begin = 1'b0;
   logic           read_end   = 1'b0;
   logic [AW-1:0]  base       = '0;
   logic [AW-1:0]  stride     = '0;
   logic [LW-1:0]  len        = '0;
   logic [CH-1:0]  ch_en      = '0;
   logic [DRC-1:0] is_drc     = '0;

   logic [CH*AW-1:0] a16, a10;
   logic [CH-1:0]    v16, v10;
   logic             b16, b10, d16, d10, ab16, ab10;
   logic [LW-1:0]    sc16, sc10;

   msgpass_rqst_addr_seq #(
      .DEPTH(16), .ADDR_WIDTH(AW), .CH_NUM(CH), .DRC_NUM(DRC), .LEN_WIDTH(LW)
   ) u16 (
      .sys_clk(sys_clk), .rstn(rstn),
      .read_begin_i(read_begin), .read_end_i(read_end),
      .base_addr_i(base), .stride_i(stride), .len_i(len),
      .ch_en_i(ch_en), .is_drc_i(is_drc),
      .addr_o(a16), .addr_valid_o(v16), .busy_o(b16),
      .done_o(d16), .aborted_o(ab16), .step_cnt_o(sc16)
   );

   msgpass_rqst_addr_seq #(
      .DEPTH(10), .ADDR_WIDTH(AW), .CH_NUM(CH), .DRC_NUM(DRC), .LEN_WIDTH(LW)
   ) u10 (
      .sys_clk(sys_clk), .rstn(rstn),
      .read_begin_i(read_begin), .read_end_i(read_end),
      .base_addr_i(base), .stride_i(stride), .len_i(len),
      .ch_en_i(ch_en), .is_drc_i(is_drc),
      .addr_o(a10), .addr_valid_o(v10), .busy_o(b10),
      .done_o(d10), .aborted_o(ab10), .step_cnt_o(sc10)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a run is "step index m_cnt of m_len"; addresses are
   // recomputed from scratch as (base + idx*stride + k) mod DEPTH.
   bit m_run, m_done, m_ab;
   int m_cnt, m_len, m_base, m_stride, m_chen;

   always @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         m_run = 0; m_done = 0; m_ab = 0;
         m_cnt = 0; m_len = 0; m_base = 0; m_stride = 0; m_chen = 0;
      end else if (m_done) begin
         m_done = 0;
         m_ab   = 0;
      end else if (!m_run) begin
         if (read_begin) begin
            m_base = int'(base); m_stride = int'(stride);
            m_len = int'(len); m_chen = int'(ch_en); m_cnt = 0;
            if (m_len == 0) m_done = 1;
            else m_run = 1;
         end
      end else if (read_end) begin
         m_run = 0; m_done = 1; m_ab = 1;
      end else if (is_drc == 0) begin
         m_cnt++;
         if (m_cnt == m_len) begin
            m_run = 0; m_done = 1;
         end
      end
   end

   function automatic logic [CH*AW-1:0] exp_addr(input int d);
      logic [CH*AW-1:0] r;
      r = '0;
      for (int k = 0; k < CH; k++)
         r[k*AW +: AW] = AW'((m_base + m_cnt * m_stride + k) % d);
      return r;
   endfunction

   always @(negedge sys_clk) begin
      if (rstn) begin
         chk("busy16", b16, m_run);
         chk("valid16", v16, m_run ? m_chen : 0);
         chk("done16", d16, m_done);
         chk("aborted16", ab16, m_ab);
         chk("stepcnt16", sc16, m_cnt);
         if (m_run) chk("addr16", a16, exp_addr(16));
         chk("busy10", b10, m_run);
         chk("valid10", v10, m_run ? m_chen : 0);
         chk("done10", d10, m_done);
         chk("stepcnt10", sc10, m_cnt);
         if (m_run && m_base < 10 && m_stride < 10)
            chk("addr10", a10, exp_addr(10));
      end
   end

   bit               rec_en = 0;
   logic [CH*AW-1:0] q16[$];
   logic [CH*AW-1:0] q10[$];
   logic [CH*AW-1:0] exp_q[$];

   always @(negedge sys_clk) begin
      if (rec_en && rstn) begin
         if (v16 != 0) q16.push_back(a16);
         if (v10 != 0) q10.push_back(a10);
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic start(input int b, input int s, input int l, input int ce);
      base   = AW'(b);
      stride = AW'(s);
      len    = LW'(l);
      ch_en  = CH'(ce);
      read_begin = 1'b1;
      tick();
      read_begin = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((m_run || m_done) && n < budget) begin
         tick();
         n++;
      end
      if (m_run || m_done) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles", nm, n);
      end
   endtask

   task automatic rec_clear();
      q16.delete();
      q10.delete();
      exp_q.delete();
      rec_en = 1;
   endtask

   task automatic chk_rec(input string nm, input bit use10);
      int n = use10 ? q10.size() : q16.size();
      rec_en = 0;
      chk({nm, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         chk(nm, use10 ? q10[i] : q16[i], exp_q[i]);
   endtask

   initial begin
      #1 rstn = 1'b0;
      #1;
      chk("rst_addr", a16, 0);
      chk("rst_valid", v16, 0);
      chk("rst_busy", b16, 0);
      chk("rst_done", d16, 0);
      chk("rst_step", sc16, 0);
      chk("rst_valid10", v10, 0);
      #22 rstn = 1'b1;
      tick();

      // basic run
      rec_clear();
      exp_q = '{8'h10, 8'h32, 8'h54, 8'h76};
      start(0, 2, 4, 3);
      wait_idle("basic", 20);
      chk_rec("basic_pairs", 0);
      chk("basic_stepcnt", sc16, 4);

      // wrap-around at DEPTH=16
      rec_clear();
      exp_q = '{8'hfe, 8'h21, 8'h54};
      start(14, 3, 3, 3);
      wait_idle("wrap", 20);
      chk_rec("wrap_pairs", 0);

      // non-power-of-two DEPTH=10
      rec_clear();
      exp_q = '{8'h98, 8'h09, 8'h10};
      start(8, 1, 3, 3);
      wait_idle("depth10", 20);
      chk_rec("depth10_pairs", 1);

      // stall for two cycles on the second step, upper conflict bit only
      rec_clear();
      exp_q = '{8'h10, 8'h21, 8'h21, 8'h21, 8'h32};
      start(0, 1, 3, 3);
      tick();
      is_drc = 2'b10;
      tick();
      tick();
      is_drc = 2'b00;
      wait_idle("stall", 20);
      chk_rec("stall_pairs", 0);
      chk("stall_stepcnt", sc16, 3);

      // abort during third step, begin pulses while busy
      start(0, 1, 8, 3);
      tick();
      read_begin = 1'b1;
      tick();
      read_end = 1'b1;
      tick();
      read_end = 1'b0;
      chk("abort_done", d16, 1);
      chk("abort_flag", ab16, 1);
      chk("abort_valid", v16, 0);
      chk("abort_stepcnt", sc16, 2);
      tick();
      read_begin = 1'b0;
      chk("abort_no_restart", b16, 0);
      chk("abort_hold_cnt", sc16, 2);
      tick();

      // zero length
      rec_clear();
      start(3, 1, 0, 3);
      chk("len0_done", d16, 1);
      chk("len0_busy", b16, 0);
      chk("len0_valid", v16, 0);
      wait_idle("len0", 5);
      chk_rec("len0_pairs", 0);

      // reset in the middle of a stall
      start(0, 1, 5, 3);
      tick();
      is_drc = 2'b01;
      tick();
      tick();
      #3 rstn = 1'b0;
      #1;
      chk("midrst_addr", a16, 0);
      chk("midrst_valid", v16, 0);
      chk("midrst_busy", b16, 0);
      chk("midrst_done", d16, 0);
      chk("midrst_aborted", ab16, 0);
      chk("midrst_step", sc16, 0);
      is_drc = 2'b00;
      tick();
      tick();
      #3 rstn = 1'b1;
      start(5, 2, 2, 1);
      chk("postrst_start", b16, 1);
      wait_idle("postrst", 10);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         int n;
         base   = AW'($urandom_range(0, 9));
         stride = AW'($urandom_range(1, 9));
         len    = LW'($urandom_range(0, 12));
         ch_en  = CH'($urandom_range(0, 3));
         read_begin = 1'b1;
         read_end   = ($urandom_range(0, 3) == 0);
         tick();
         read_begin = 1'b0;
         read_end   = 1'b0;
         n = 0;
         while ((m_run || m_done) && n < 200) begin
            is_drc = ($urandom_range(0, 3) == 0) ? DRC'($urandom_range(1, 3)) : '0;
            read_end   = ($urandom_range(0, 29) == 0);
            read_begin = m_run && ($urandom_range(0, 7) == 0);
            tick();
            n++;
         end
         if (m_run || m_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL rand_timeout: run %0d did not finish", r);
         end
         is_drc     = '0;
         read_begin = 1'b0;
         read_end   = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            read_end = $urandom_range(0, 1);
            tick();
         end
         read_end = 1'b0;
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
